dlx_mem_slave: RTL

- Word-addressed synchronous memory slave sitting directly downstream of the DLX memory-access controller.
- Consumes the controller's AS_N/WR_N strobes, address and write data. Returns read data and a one-cycle ACK_N after a parameterised number of wait states.
- Used as the program/data store in simulation and FPGA bring-up. Exercises the controller's BUSY/STOP_N/IR_CE timing under wait states.

---
 rtl/dlx_mem_slave.sv | 111 +++++++++++
 1 files changed

// File: rtl/dlx_mem_slave.sv
// Word-addressed memory slave for the DLX memory-access controller.
// Acks each AS_N request with a one-cycle ACK_N after WAIT_STATES cycles; REC blocks re-triggering on a held strobe.
module dlx_mem_slave #(
  parameter int AW          = 10,
  parameter int DEPTH       = 1024,
  parameter int WAIT_STATES = 2
) (
  input  logic          CLK,
  input  logic          RESET_N,
  input  logic          AS_N,
  input  logic          WR_N,
  input  logic [AW-1:0] ADDR,
  input  logic [31:0]   DIN,
  output logic [31:0]   DOUT,
  output logic          ACK_N,
  output logic          ERR,
  output logic [1:0]    BUS_STATE
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_WAIT = 2'b01,
    S_ACK  = 2'b10,
    S_REC  = 2'b11
  } state_t;

  state_t        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          latch;
  logic [AW-1:0] req_addr;
  logic          req_wr_n;
  logic [31:0]   req_din;
  logic [31:0]   mem [DEPTH];

  logic          go_ack;
  logic [AW-1:0] acc_addr;
  logic          acc_wr_n;
  logic [31:0]   acc_din;
  logic          in_range;
  logic [IW-1:0] idx;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    latch   = 1'b0;
    unique case (state_q)
      S_IDLE: if (!AS_N) begin
        latch = 1'b1;
        if (WAIT_STATES == 0) state_d = S_ACK;
        else begin
          state_d = S_WAIT;
          cnt_d   = 4'(WAIT_STATES);
        end
      end
      // abort takes priority over a terminal count
      S_WAIT: if (AS_N)              state_d = S_IDLE;
              else if (cnt_q == 4'd1) state_d = S_ACK;
              else                    cnt_d   = cnt_q - 4'd1;
      S_ACK:  state_d = S_REC;
      S_REC:  if (AS_N) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q  <= S_IDLE;
      cnt_q    <= 4'd0;
      req_addr <= '0;
      req_wr_n <= 1'b1;
      req_din  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (latch) begin
        req_addr <= ADDR;
        req_wr_n <= WR_N;
        req_din  <= DIN;
      end
    end
  end

  // With zero wait states the access happens on the sampling edge itself, so use the live bus.
  assign acc_addr = (state_q == S_IDLE) ? ADDR : req_addr;
  assign acc_wr_n = (state_q == S_IDLE) ? WR_N : req_wr_n;
  assign acc_din  = (state_q == S_IDLE) ? DIN  : req_din;
  assign in_range = {1'b0, acc_addr} < (AW+1)'(DEPTH);
  assign idx      = acc_addr[IW-1:0];
  assign go_ack   = RESET_N && (state_d == S_ACK) && (state_q != S_ACK);

  always_ff @(posedge CLK) begin
    if (go_ack && !acc_wr_n && in_range) mem[idx] <= acc_din;
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      ACK_N <= 1'b1;
      ERR   <= 1'b0;
      DOUT  <= '0;
    end else begin
      ACK_N <= !go_ack;
      ERR   <= go_ack && !in_range;
      if (go_ack && acc_wr_n) DOUT <= in_range ? mem[idx] : 32'd0;
    end
  end

  assign BUS_STATE = state_q;

endmodule
